// File: rtl/nes_mem_router.sv
// NES memory front-end: round-robin arbiter for CPU/PPU request ports onto one map.
// CPU-RAM and VRAM live in internal block RAMs; PRG/CHR/cart-RAM go out on the cart port.
module nes_mem_router #(
  parameter int ADDR_W  = 22,
  parameter int DATA_W  = 8,
  parameter int RAM_AW  = 11,
  parameter int TIMEOUT = 255
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              ppu_req,
  input  logic              ppu_we,
  input  logic [ADDR_W-1:0] ppu_addr,
  input  logic [DATA_W-1:0] ppu_wdata,
  output logic              ppu_ack,
  output logic              ppu_rvalid,
  output logic [DATA_W-1:0] ppu_rdata,
  input  logic              cart_ready,
  output logic              cart_req,
  output logic              cart_we,
  output logic [2:0]        cart_sel,
  output logic [20:0]       cart_addr,
  output logic [DATA_W-1:0] cart_wdata,
  input  logic [DATA_W-1:0] cart_rdata,
  input  logic              cart_rvalid,
  output logic              err_timeout
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, RAM_RD, CART_WAIT} state_e;
  typedef enum logic [2:0] {T_PRG, T_CHR, T_VRAM, T_CRAM, T_CRT, T_NONE} tgt_e;

  function automatic tgt_e decode(input logic [3:0] top);
    tgt_e t;
    casez (top)
      4'b0???: t = T_PRG;
      4'b10??: t = T_CHR;
      4'b1100: t = T_VRAM;
      4'b1110: t = T_CRAM;
      4'b1111: t = T_CRT;
      default: t = T_NONE;
    endcase
    return t;
  endfunction

  function automatic logic is_cart(input tgt_e t);
    return (t == T_PRG) || (t == T_CHR) || (t == T_CRT);
  endfunction

  state_e            state_q, state_d;
  tgt_e              tgt_q, tgt_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_ppu_q, last_ppu_d;
  logic              port_ppu_q, port_ppu_d;
  logic              cpu_ack_q, cpu_ack_d, ppu_ack_q, ppu_ack_d;
  logic              cpu_rvalid_q, cpu_rvalid_d, ppu_rvalid_q, ppu_rvalid_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d, ppu_rdata_q, ppu_rdata_d;
  logic              cart_req_q, cart_req_d, cart_we_q, cart_we_d;
  logic [2:0]        cart_sel_q, cart_sel_d;
  logic [20:0]       cart_addr_q, cart_addr_d;
  logic [DATA_W-1:0] cart_wdata_q, cart_wdata_d;
  logic              err_q, err_d;

  logic              cpu_elig, ppu_elig, free, grant_cpu, grant_ppu, grant_any;
  logic              g_we;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_wdata;
  tgt_e              g_tgt;
  logic              done;
  logic [DATA_W-1:0] done_data;
  logic [DATA_W-1:0] vram_q, cram_q;
  logic [RAM_AW-1:0] ram_a;

  // A port whose ack is showing is masked so a still-held req is not served twice.
  assign cpu_elig  = cpu_req && !cpu_ack_q &&
                     (!is_cart(decode(cpu_addr[ADDR_W-1 -: 4])) || cart_ready);
  assign ppu_elig  = ppu_req && !ppu_ack_q &&
                     (!is_cart(decode(ppu_addr[ADDR_W-1 -: 4])) || cart_ready);
  // The next grant may share the edge that completes the outstanding read.
  assign free      = (state_q != CART_WAIT) || cart_rvalid || (cnt_q == CNT_W'(TIMEOUT - 1));
  assign grant_ppu = free && ppu_elig && (!cpu_elig || !last_ppu_q);
  assign grant_cpu = free && cpu_elig && !grant_ppu;
  assign grant_any = grant_cpu || grant_ppu;
  assign g_we      = grant_ppu ? ppu_we    : cpu_we;
  assign g_addr    = grant_ppu ? ppu_addr  : cpu_addr;
  assign g_wdata   = grant_ppu ? ppu_wdata : cpu_wdata;
  assign g_tgt     = decode(g_addr[ADDR_W-1 -: 4]);
  assign ram_a     = g_addr[RAM_AW-1:0];

  always_comb begin
    state_d = state_q;         tgt_d = tgt_q;              cnt_d = cnt_q;
    last_ppu_d = last_ppu_q;   port_ppu_d = port_ppu_q;
    cpu_ack_d = 1'b0;          ppu_ack_d = 1'b0;
    cpu_rvalid_d = 1'b0;       ppu_rvalid_d = 1'b0;
    cpu_rdata_d = cpu_rdata_q; ppu_rdata_d = ppu_rdata_q;
    cart_req_d = 1'b0;         cart_we_d = 1'b0;
    cart_sel_d = cart_sel_q;   cart_addr_d = cart_addr_q;  cart_wdata_d = cart_wdata_q;
    err_d = err_q;
    done = 1'b0;               done_data = '0;
    case (state_q)
      RAM_RD: begin
        done = 1'b1;
        done_data = (tgt_q == T_VRAM) ? vram_q : (tgt_q == T_CRAM) ? cram_q : '0;
      end
      CART_WAIT: begin
        if (cart_rvalid) begin
          done = 1'b1;
          done_data = cart_rdata;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          done = 1'b1;
          done_data = '1;
          err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
    if (done) begin
      state_d = IDLE;
      if (port_ppu_q) begin
        ppu_rvalid_d = 1'b1;
        ppu_rdata_d  = done_data;
      end else begin
        cpu_rvalid_d = 1'b1;
        cpu_rdata_d  = done_data;
      end
    end
    if (grant_any) begin
      cpu_ack_d  = grant_cpu;
      ppu_ack_d  = grant_ppu;
      last_ppu_d = grant_ppu;
      port_ppu_d = grant_ppu;
      tgt_d      = g_tgt;
      if (is_cart(g_tgt)) begin
        cart_req_d   = 1'b1;
        cart_we_d    = g_we;
        cart_wdata_d = g_wdata;
        case (g_tgt)
          T_PRG:   begin cart_sel_d = 3'b001; cart_addr_d = g_addr[20:0];           end
          T_CHR:   begin cart_sel_d = 3'b010; cart_addr_d = {1'b0, g_addr[19:0]};   end
          default: begin cart_sel_d = 3'b100; cart_addr_d = {3'b000, g_addr[17:0]}; end
        endcase
        if (!g_we) begin
          state_d = CART_WAIT;
          cnt_d   = '0;
        end
      end else if (!g_we) begin
        state_d = RAM_RD;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;        tgt_q <= T_NONE;        cnt_q <= '0;
      last_ppu_q <= 1'b0;     port_ppu_q <= 1'b0;
      cpu_ack_q <= 1'b0;      ppu_ack_q <= 1'b0;
      cpu_rvalid_q <= 1'b0;   ppu_rvalid_q <= 1'b0;
      cpu_rdata_q <= '0;      ppu_rdata_q <= '0;
      cart_req_q <= 1'b0;     cart_we_q <= 1'b0;
      cart_sel_q <= '0;       cart_addr_q <= '0;      cart_wdata_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;     tgt_q <= tgt_d;         cnt_q <= cnt_d;
      last_ppu_q <= last_ppu_d; port_ppu_q <= port_ppu_d;
      cpu_ack_q <= cpu_ack_d; ppu_ack_q <= ppu_ack_d;
      cpu_rvalid_q <= cpu_rvalid_d; ppu_rvalid_q <= ppu_rvalid_d;
      cpu_rdata_q <= cpu_rdata_d;   ppu_rdata_q <= ppu_rdata_d;
      cart_req_q <= cart_req_d; cart_we_q <= cart_we_d;
      cart_sel_q <= cart_sel_d; cart_addr_q <= cart_addr_d; cart_wdata_q <= cart_wdata_d;
      err_q <= err_d;
    end
  end

  logic [DATA_W-1:0] vram [2**RAM_AW];
  logic [DATA_W-1:0] cram [2**RAM_AW];

  always_ff @(posedge clock) begin
    if (grant_any && g_tgt == T_VRAM) begin
      if (g_we) vram[ram_a] <= g_wdata;
      vram_q <= vram[ram_a];
    end
  end

  always_ff @(posedge clock) begin
    if (grant_any && g_tgt == T_CRAM) begin
      if (g_we) cram[ram_a] <= g_wdata;
      cram_q <= cram[ram_a];
    end
  end

  assign cpu_ack     = cpu_ack_q;
  assign cpu_rvalid  = cpu_rvalid_q;
  assign cpu_rdata   = cpu_rdata_q;
  assign ppu_ack     = ppu_ack_q;
  assign ppu_rvalid  = ppu_rvalid_q;
  assign ppu_rdata   = ppu_rdata_q;
  assign cart_req    = cart_req_q;
  assign cart_we     = cart_we_q;
  assign cart_sel    = cart_sel_q;
  assign cart_addr   = cart_addr_q;
  assign cart_wdata  = cart_wdata_q;
  assign err_timeout = err_q;
endmodule
